// File: rtl/battleship_board_ctrl.sv
// battleship_board_ctrl
//   Dual NxN board store (player board and PC board) for the battleship game.
//   Place and attack commands arrive from the game FSM over a valid/ready
//   handshake. Each accepted command produces exactly one response strobe,
//   unless a reset or clear aborts it first.
//
//   Build option: define BOARD_OVERLAP_CHECK_EN to reject placements that
//   touch any non-WATER cell. Without it, overlapping cells are overwritten
//   with SHIP, and only newly created SHIP cells are added to the counter.
//
// Ports
//   clk, rst                      rising-edge clock, async active-low reset
//   clear                         synchronous wipe of both boards; aborts any command
//   cmd_valid/cmd_ready           command handshake
//   cmd_op                        0 PLACE_PLAYER, 1 PLACE_PC, 2 ATTACK_PC, 3 ATTACK_PLAYER
//   cmd_row/cmd_col               anchor or target cell
//   cmd_len/cmd_vert              ship length and orientation (place only)
//   rsp_valid/rsp_code            one-cycle strobe; code 0 OK, 1 HIT, 2 MISS, 3 REJECT
//   player_left/pc_left           unhit ship cells per board
//   player_defeated/pc_defeated   board has ships, and all of them are hit
//   rd_row/rd_col                 renderer read address
//   rd_player/rd_pc               combinational cell codes (00 outside the grid)
//
//   Cell codes: 00 WATER, 01 SHIP, 10 HIT_SHIP, 11 MISS_WATER
module battleship_board_ctrl #(
  parameter int N    = 5,
  parameter int CW   = 3,
  parameter int LW   = 3,
  parameter int CNTW = $clog2(N*N+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [CW-1:0]   cmd_row,
  input  logic [CW-1:0]   cmd_col,
  input  logic [LW-1:0]   cmd_len,
  input  logic            cmd_vert,
  output logic            rsp_valid,
  output logic [1:0]      rsp_code,
  output logic [CNTW-1:0] player_left,
  output logic [CNTW-1:0] pc_left,
  output logic            player_defeated,
  output logic            pc_defeated,
  input  logic [CW-1:0]   rd_row,
  input  logic [CW-1:0]   rd_col,
  output logic [1:0]      rd_player,
  output logic [1:0]      rd_pc
);

  localparam int NC = N * N;
  localparam int IW = $clog2(NC);
  localparam int AW = CW + LW;   // wide enough that anchor + offset never wraps
  localparam int XW = 2 * AW;

  localparam logic [1:0] WATER = 2'b00, SHIP = 2'b01, HIT_SHIP = 2'b10, MISS_WATER = 2'b11;
  localparam logic [1:0] RSP_OK = 2'd0, RSP_HIT = 2'd1, RSP_MISS = 2'd2, RSP_REJECT = 2'd3;
  localparam logic [1:0] OP_PLACE_PLAYER = 2'd0, OP_ATTACK_PLAYER = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE, S_RESP} state_t;
  state_t state_reg, state_next;

  logic [1:0]      op_reg, code_reg;
  logic [CW-1:0]   row_reg, col_reg;
  logic [LW-1:0]   len_reg, k_reg;
  logic            vert_reg;
  logic [CNTW-1:0] player_left_reg, pc_left_reg;
  logic            player_placed_reg, pc_placed_reg;
  logic            player_def_reg, pc_def_reg;
  logic [2*NC-1:0] player_flat, pc_flat;

  // Strobes from the output process
  logic            wr_en, k_inc, k_clr, cnt_inc, cnt_dec, code_load, placed_set;
  logic [1:0]      wr_data, code_val;

  // Cell currently visited: anchor plus offset k along the ship's axis
  logic [AW-1:0] k_ext, cur_row, cur_col;
  logic [IW-1:0] cur_idx;
  logic [1:0]    cur_cell;
  logic          cur_in_grid, tgt_player, is_place, last_k, place_fail, attack_fail, place_block;

  assign k_ext       = AW'(k_reg);
  assign cur_row     = AW'(row_reg) + (vert_reg ? k_ext : '0);
  assign cur_col     = AW'(col_reg) + (vert_reg ? '0 : k_ext);
  assign cur_in_grid = (cur_row < AW'(N)) && (cur_col < AW'(N));
  assign cur_idx     = IW'(XW'(cur_row) * XW'(N) + XW'(cur_col));
  assign tgt_player  = (op_reg == OP_PLACE_PLAYER) || (op_reg == OP_ATTACK_PLAYER);
  assign is_place    = ~op_reg[1];
  assign cur_cell    = tgt_player ? player_flat[{cur_idx, 1'b0} +: 2] : pc_flat[{cur_idx, 1'b0} +: 2];
  assign last_k      = (k_reg == len_reg - LW'(1));

`ifdef BOARD_OVERLAP_CHECK_EN
  assign place_block = (cur_cell != WATER);
`else
  assign place_block = 1'b0;
`endif

  assign place_fail  = (len_reg == '0) || !cur_in_grid || place_block;
  assign attack_fail = !cur_in_grid || cur_cell[1];  // already HIT_SHIP or MISS_WATER

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (cmd_valid) state_next = S_CHECK;
        S_CHECK: begin
          if (!is_place)       state_next = S_RESP;
          else if (place_fail) state_next = S_RESP;
          else if (last_k)     state_next = S_WRITE;
        end
        S_WRITE: if (last_k) state_next = S_RESP;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Output and datapath strobes
  always_comb begin
    cmd_ready  = (state_reg == S_IDLE) && !clear;
    rsp_valid  = (state_reg == S_RESP) && !clear;
    wr_en      = 1'b0;
    wr_data    = WATER;
    k_inc      = 1'b0;
    k_clr      = 1'b0;
    cnt_inc    = 1'b0;
    cnt_dec    = 1'b0;
    code_load  = 1'b0;
    code_val   = RSP_OK;
    placed_set = 1'b0;
    if (!clear) begin
      case (state_reg)
        S_CHECK: begin
          if (is_place) begin
            if (place_fail) begin
              code_load = 1'b1;
              code_val  = RSP_REJECT;
            end else if (last_k) begin
              k_clr = 1'b1;
            end else begin
              k_inc = 1'b1;
            end
          end else begin
            code_load = 1'b1;
            if (attack_fail) begin
              code_val = RSP_REJECT;
            end else if (cur_cell == SHIP) begin
              wr_en    = 1'b1;
              wr_data  = HIT_SHIP;
              cnt_dec  = 1'b1;
              code_val = RSP_HIT;
            end else begin
              wr_en    = 1'b1;
              wr_data  = MISS_WATER;
              code_val = RSP_MISS;
            end
          end
        end
        S_WRITE: begin
          wr_en   = 1'b1;
          wr_data = SHIP;
          cnt_inc = (cur_cell != SHIP);  // keeps the count exact on overlap
          if (last_k) begin
            code_load  = 1'b1;
            code_val   = RSP_OK;
            placed_set = 1'b1;
          end else begin
            k_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Command latch, step counter, response code, ship counters, flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_reg <= '0; row_reg <= '0; col_reg <= '0; len_reg <= '0; vert_reg <= 1'b0;
      k_reg <= '0; code_reg <= RSP_OK;
      player_left_reg <= '0; pc_left_reg <= '0;
      player_placed_reg <= 1'b0; pc_placed_reg <= 1'b0;
      player_def_reg <= 1'b0; pc_def_reg <= 1'b0;
    end else if (clear) begin
      k_reg <= '0;
      player_left_reg <= '0; pc_left_reg <= '0;
      player_placed_reg <= 1'b0; pc_placed_reg <= 1'b0;
      player_def_reg <= 1'b0; pc_def_reg <= 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        op_reg <= cmd_op; row_reg <= cmd_row; col_reg <= cmd_col;
        len_reg <= cmd_len; vert_reg <= cmd_vert; k_reg <= '0;
      end else if (k_clr) begin
        k_reg <= '0;
      end else if (k_inc) begin
        k_reg <= k_reg + LW'(1);
      end
      if (code_load) code_reg <= code_val;
      if (cnt_inc) begin
        if (tgt_player) player_left_reg <= player_left_reg + CNTW'(1);
        else            pc_left_reg     <= pc_left_reg + CNTW'(1);
      end
      if (cnt_dec) begin
        if (tgt_player) player_left_reg <= player_left_reg - CNTW'(1);
        else            pc_left_reg     <= pc_left_reg - CNTW'(1);
      end
      if (placed_set) begin
        if (tgt_player) player_placed_reg <= 1'b1;
        else            pc_placed_reg     <= 1'b1;
      end
      // Registered, so defeat shows one cycle after the final HIT strobe
      player_def_reg <= player_placed_reg && (player_left_reg == '0);
      pc_def_reg     <= pc_placed_reg && (pc_left_reg == '0);
    end
  end

  // Board cells: one 2-bit register per cell per board
  genvar gi;
  generate
    for (gi = 0; gi < NC; gi++) begin : g_cell
      logic [1:0] player_cell_reg, pc_cell_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          player_cell_reg <= WATER;
          pc_cell_reg     <= WATER;
        end else if (clear) begin
          player_cell_reg <= WATER;
          pc_cell_reg     <= WATER;
        end else if (wr_en && (cur_idx == IW'(gi))) begin
          if (tgt_player) player_cell_reg <= wr_data;
          else            pc_cell_reg     <= wr_data;
        end
      end
      assign player_flat[2*gi +: 2] = player_cell_reg;
      assign pc_flat[2*gi +: 2]     = pc_cell_reg;
    end
  endgenerate

  // Renderer read ports; compared one bit wider so N == 2**CW still works
  logic          rd_in_grid;
  logic [IW-1:0] rd_idx;
  assign rd_in_grid = ((CW+1)'(rd_row) < (CW+1)'(N)) && ((CW+1)'(rd_col) < (CW+1)'(N));
  assign rd_idx     = IW'((2*CW+2)'(rd_row) * (2*CW+2)'(N) + (2*CW+2)'(rd_col));
  assign rd_player  = rd_in_grid ? player_flat[{rd_idx, 1'b0} +: 2] : WATER;
  assign rd_pc      = rd_in_grid ? pc_flat[{rd_idx, 1'b0} +: 2] : WATER;

  assign rsp_code        = code_reg;
  assign player_left     = player_left_reg;
  assign pc_left         = pc_left_reg;
  assign player_defeated = player_def_reg;
  assign pc_defeated     = pc_def_reg;

endmodule
